// File: rtl/axi4_pkg.sv
// Shared AXI4 types, response codes and burst address arithmetic for the burst memory subordinate.
package axi4_pkg;

    typedef enum logic [1:0] {FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2} burst_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_DATA} rd_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int AXI_ADDR_MAX_W = 64;

    // Computed at the widest supported address; callers keep the low ADDR_W bits (modulo wrap).
    function automatic logic [AXI_ADDR_MAX_W-1:0] axi_next_addr(
        input logic [AXI_ADDR_MAX_W-1:0] addr,
        input logic [7:0]                len,
        input logic [2:0]                size,
        input logic [1:0]                burst
    );
        logic [AXI_ADDR_MAX_W-1:0] incr;
        logic [AXI_ADDR_MAX_W-1:0] wb;
        incr = AXI_ADDR_MAX_W'(1) << size;
        wb   = (AXI_ADDR_MAX_W'(len) + AXI_ADDR_MAX_W'(1)) << size;
        case (burst_e'(burst))
            INCR:    return ((addr >> size) << size) + incr;
            WRAP:    return (addr & ~(wb - 1'b1)) | ((addr + incr) & (wb - 1'b1));
            default: return addr;
        endcase
    endfunction

    function automatic logic axi_burst_legal(
        input logic [7:0]                len,
        input logic [2:0]                size,
        input logic [1:0]                burst,
        input logic [AXI_ADDR_MAX_W-1:0] addr,
        input logic [2:0]                max_size
    );
        logic ok;
        ok = 1'b1;
        if (size > max_size) ok = 1'b0;
        if (burst == 2'b11) ok = 1'b0;
        if (burst == WRAP) begin
            if (!(len inside {8'd1, 8'd3, 8'd7, 8'd15})) ok = 1'b0;
            if ((addr & ((AXI_ADDR_MAX_W'(1) << size) - 1'b1)) != '0) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Per-direction beat address/counter: loads on the Ax handshake, steps on each data beat handshake.
module axi4_burst_addr_gen
    import axi4_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        len_i,
    input  logic [2:0]        size_i,
    input  logic [1:0]        burst_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [ADDR_W-1:0] addr_nxt_o,
    output logic              illegal_o,
    output logic              illegal_nxt_o,
    output logic              last_o
);

    localparam int MAX_SIZE = $clog2(DATA_W / 8);

    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [7:0]                len_q;
    logic [2:0]                size_q;
    logic [1:0]                burst_q;
    logic [8:0]                rem_q;
    logic                      illegal_q, illegal_d;
    logic [AXI_ADDR_MAX_W-1:0] next_full;

    assign next_full = axi_next_addr(AXI_ADDR_MAX_W'(addr_q), len_q, size_q, burst_q);

    generate
        if (ADDR_W < AXI_ADDR_MAX_W) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^next_full[AXI_ADDR_MAX_W-1:ADDR_W];
        end
    endgenerate

    // The _d values are what the register holds after this edge; the read side fetches from them.
    always_comb begin
        addr_d    = addr_q;
        illegal_d = illegal_q;
        if (load_i) begin
            addr_d    = addr_i;
            illegal_d = !axi_burst_legal(len_i, size_i, burst_i, AXI_ADDR_MAX_W'(addr_i), 3'(MAX_SIZE));
        end else if (step_i) begin
            addr_d = next_full[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            rem_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            illegal_q <= illegal_d;
            if (load_i) begin
                len_q   <= len_i;
                size_q  <= size_i;
                burst_q <= burst_i;
                rem_q   <= 9'(len_i) + 9'd1;
            end else if (step_i && rem_q != '0) begin
                rem_q <= rem_q - 9'd1;
            end
        end
    end

    assign addr_o        = addr_q;
    assign addr_nxt_o    = addr_d;
    assign illegal_o     = illegal_q;
    assign illegal_nxt_o = illegal_d;
    assign last_o        = (rem_q == 9'd1);

endmodule

// File: rtl/axi4_burst_mem_subordinate.sv
// AXI4 burst memory subordinate: byte RAM behind independent write (AW/W/B) and read (AR/R) FSMs.
module axi4_burst_mem_subordinate
    import axi4_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int ID_W      = 4,
    parameter int MEM_BYTES = 4096
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [ID_W-1:0]     AWID,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [7:0]          AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [ID_W-1:0]     ARID,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic [7:0]          ARLEN,
    input  logic [2:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [ID_W-1:0]     RID,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY
);

    localparam int BYTES  = DATA_W / 8;
    localparam int LSB    = $clog2(BYTES);
    localparam int MEM_AW = $clog2(MEM_BYTES);
    // A beat is out of range when its aligned base exceeds this limit.
    localparam logic [ADDR_W-1:0] OOB_LIM = ADDR_W'(MEM_BYTES - BYTES);

    logic [7:0] mem [MEM_BYTES];

    wr_state_e         w_state_q;
    rd_state_e         r_state_q;
    logic              awready_q, wready_q, bvalid_q, werr_q;
    logic [ID_W-1:0]   wid_q, bid_q, rid_q;
    logic [1:0]        bresp_q, rresp_q;
    logic              arready_q, rvalid_q;
    logic [DATA_W-1:0] rdata_q, rd_word;

    logic              aw_fire, w_fire, ar_fire, r_fire, r_fetch;
    logic [ADDR_W-1:0] w_addr, w_addr_nxt, w_base, r_addr, r_addr_nxt, r_base;
    logic              w_ill, w_ill_nxt, w_last, w_oob, w_beat_err;
    logic              r_ill, r_ill_nxt, r_last, r_oob;
    logic              unused_gen;

    assign aw_fire = AWVALID && awready_q;
    assign w_fire  = WVALID && wready_q;
    assign ar_fire = ARVALID && arready_q;
    assign r_fire  = rvalid_q && RREADY;
    assign r_fetch = ar_fire || (r_fire && !r_last);

    axi4_burst_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wgen (
        .clk_i(ACLK), .rst_ni(ARESETn), .load_i(aw_fire), .step_i(w_fire),
        .addr_i(AWADDR), .len_i(AWLEN), .size_i(AWSIZE), .burst_i(AWBURST),
        .addr_o(w_addr), .addr_nxt_o(w_addr_nxt), .illegal_o(w_ill),
        .illegal_nxt_o(w_ill_nxt), .last_o(w_last)
    );

    axi4_burst_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rgen (
        .clk_i(ACLK), .rst_ni(ARESETn), .load_i(ar_fire), .step_i(r_fire),
        .addr_i(ARADDR), .len_i(ARLEN), .size_i(ARSIZE), .burst_i(ARBURST),
        .addr_o(r_addr), .addr_nxt_o(r_addr_nxt), .illegal_o(r_ill),
        .illegal_nxt_o(r_ill_nxt), .last_o(r_last)
    );

    assign unused_gen = ^{w_addr_nxt, w_ill_nxt, r_addr, r_ill};

    assign w_base     = {w_addr[ADDR_W-1:LSB], {LSB{1'b0}}};
    assign w_oob      = (w_base > OOB_LIM);
    assign w_beat_err = w_ill || w_oob || (WLAST != w_last);
    assign r_base     = {r_addr_nxt[ADDR_W-1:LSB], {LSB{1'b0}}};
    assign r_oob      = (r_base > OOB_LIM);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            wid_q     <= '0;
            werr_q    <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: if (aw_fire) begin
                    wid_q     <= AWID;
                    werr_q    <= 1'b0;
                    awready_q <= 1'b0;
                    wready_q  <= 1'b1;
                    w_state_q <= W_DATA;
                end
                W_DATA: if (w_fire) begin
                    werr_q <= werr_q || w_beat_err;
                    // Burst length comes from AWLEN; WLAST only feeds the error check.
                    if (w_last) begin
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bid_q     <= wid_q;
                        bresp_q   <= (werr_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: if (BREADY) begin
                    bvalid_q  <= 1'b0;
                    awready_q <= 1'b1;
                    w_state_q <= W_IDLE;
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_fire && !w_ill && !w_oob) begin
            for (int l = 0; l < BYTES; l++) begin
                if (WSTRB[l]) mem[w_base[MEM_AW-1:0] + MEM_AW'(l)] <= WDATA[l*8 +: 8];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int l = 0; l < BYTES; l++) begin
            rd_word[l*8 +: 8] = mem[r_base[MEM_AW-1:0] + MEM_AW'(l)];
        end
    end

    // Fetch lands on the same edge the beat address advances, so a same-cycle write is not seen.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (r_fetch) begin
            rdata_q <= (r_ill_nxt || r_oob) ? '0 : rd_word;
            rresp_q <= (r_ill_nxt || r_oob) ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: if (ar_fire) begin
                    rid_q     <= ARID;
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b1;
                    r_state_q <= R_DATA;
                end
                R_DATA: if (r_fire && r_last) begin
                    rvalid_q  <= 1'b0;
                    arready_q <= 1'b1;
                    r_state_q <= R_IDLE;
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = bid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RID     = rid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rvalid_q && r_last;

endmodule

// File: tb/tb_axi4_burst_mem_subordinate.sv
// Directed bench for the AXI4 burst memory subordinate with hand-computed expectations.
module tb_axi4_burst_mem_subordinate;

    logic        ACLK, ARESETn;
    logic [3:0]  AWID, BID, ARID, RID;
    logic [31:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN, WSTRB;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [63:0] WDATA, RDATA;

    int tests = 0;
    int fails = 0;

    logic [63:0] wd [16];
    logic [7:0]  ws [16];
    logic [63:0] ed [16];
    logic [1:0]  er [16];
    logic [63:0] rdat [16];
    logic [1:0]  rrsp [16];
    logic        rlst [16];
    logic [3:0]  rids [16];

    axi4_burst_mem_subordinate dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Waits (bounded) for the ready of channel ch (0=AW, 1=W, 2=AR) and completes the handshake.
    task automatic hs(input int ch);
        int   n;
        logic rdy;
        n = 0;
        @(negedge ACLK);
        rdy = (ch == 0) ? AWREADY : (ch == 1) ? WREADY : ARREADY;
        while (!rdy && n < 200) begin
            @(negedge ACLK);
            rdy = (ch == 0) ? AWREADY : (ch == 1) ? WREADY : ARREADY;
            n++;
        end
        if (!rdy) chk("hs_timeout", rdy, 1);
        @(posedge ACLK); #1;
    endtask

    task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst, input int lastbeat,
                      input int bhold, input logic [1:0] exp_resp, input string tag);
        int n;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        hs(0);
        AWVALID = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            WVALID = 1'b1; WDATA = wd[b]; WSTRB = ws[b]; WLAST = (b == lastbeat);
            hs(1);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        n = 0;
        @(negedge ACLK);
        while (!BVALID && n < 200) begin @(negedge ACLK); n++; end
        for (int k = 0; k < bhold; k++) begin
            chk({tag, "_bhold_valid"}, BVALID, 1);
            chk({tag, "_bhold_id"}, BID, id);
            chk({tag, "_bhold_resp"}, BRESP, exp_resp);
            chk({tag, "_awready_blocked"}, AWREADY, 0);
            @(negedge ACLK);
        end
        chk({tag, "_bvalid"}, BVALID, 1);
        chk({tag, "_bid"}, BID, id);
        chk({tag, "_bresp"}, BRESP, exp_resp);
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        chk({tag, "_awready_back"}, AWREADY, 1);
    endtask

    // bp=1 drives RREADY with the repeating pattern 1,0,0,1 and checks stall stability.
    task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst, input bit bp, input string tag);
        int         nb, c;
        logic [3:0] pat;
        logic       stalled;
        logic [70:0] snap;
        pat = 4'b1001; nb = 0; c = 0; stalled = 1'b0; snap = '0;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        hs(2);
        ARVALID = 1'b0;
        while (nb <= int'(len) && c < 2000) begin
            RREADY = bp ? pat[c % 4] : 1'b1;
            @(negedge ACLK);
            if (stalled) chk({tag, "_stall_stable"}, {RVALID, RDATA, RRESP, RLAST, RID}, {1'b1, snap});
            stalled = RVALID && !RREADY;
            snap = {RDATA, RRESP, RLAST, RID};
            if (RVALID && RREADY) begin
                rdat[nb] = RDATA; rrsp[nb] = RRESP; rlst[nb] = RLAST; rids[nb] = RID;
                nb++;
            end
            @(posedge ACLK); #1;
            c++;
        end
        RREADY = 1'b0;
        chk({tag, "_beats"}, nb, int'(len) + 1);
        chk({tag, "_arready_back"}, ARREADY, 1);
        for (int b = 0; b <= int'(len); b++) begin
            chk({tag, "_data"}, rdat[b], ed[b]);
            chk({tag, "_resp"}, rrsp[b], er[b]);
            chk({tag, "_last"}, rlst[b], (b == int'(len)));
            chk({tag, "_rid"}, rids[b], id);
        end
    endtask

    task automatic fill(input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                        input logic [63:0] d3, input logic [7:0] strb);
        wd[0] = d0; wd[1] = d1; wd[2] = d2; wd[3] = d3;
        for (int i = 0; i < 4; i++) ws[i] = strb;
    endtask

    task automatic expect4(input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                           input logic [63:0] d3, input logic [1:0] rsp);
        ed[0] = d0; ed[1] = d1; ed[2] = d2; ed[3] = d3;
        for (int i = 0; i < 4; i++) er[i] = rsp;
    endtask

    initial begin
        ARESETn = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_awready", AWREADY, 1);
        chk("rst_arready", ARREADY, 1);
        chk("rst_wready", WREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rlast", RLAST, 0);
        chk("rst_ids", {BID, RID}, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_resps", {BRESP, RRESP}, 0);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(posedge ACLK); #1;

        fill(64'h5555_5555_5555_5555, 0, 0, 0, 8'hFF);
        wr(4'd1, 32'h000, 8'd0, 3'd3, 2'd1, 0, 0, 2'b00, "pre0");

        fill(64'd1, 64'd2, 64'd3, 64'd4, 8'hFF);
        wr(4'd5, 32'h100, 8'd3, 3'd3, 2'd1, 3, 0, 2'b00, "incr_w");
        expect4(64'd1, 64'd2, 64'd3, 64'd4, 2'b00);
        rd(4'd6, 32'h100, 8'd3, 3'd3, 2'd1, 1'b0, "incr_r");

        fill(64'hA0, 64'hA1, 64'hA2, 64'hA3, 8'hFF);
        wr(4'd2, 32'h118, 8'd3, 3'd3, 2'd2, 3, 0, 2'b00, "wrap_w");
        expect4(64'hA0, 64'hA1, 64'hA2, 64'hA3, 2'b00);
        rd(4'd3, 32'h118, 8'd3, 3'd3, 2'd2, 1'b0, "wrap_r");
        expect4(64'hA1, 64'hA2, 64'hA3, 64'hA0, 2'b00);
        rd(4'd4, 32'h100, 8'd3, 3'd3, 2'd1, 1'b0, "wrap_incr_r");

        fill(64'hEE, 64'hEE, 64'hEE, 0, 8'hFF);
        wr(4'd8, 32'h100, 8'd2, 3'd3, 2'd2, 2, 0, 2'b10, "wrap_bad_w");
        expect4(64'hA1, 0, 0, 0, 2'b00);
        rd(4'd8, 32'h100, 8'd0, 3'd3, 2'd1, 1'b0, "wrap_bad_unchanged");
        expect4(0, 0, 0, 0, 2'b10);
        rd(4'd9, 32'h100, 8'd2, 3'd3, 2'd2, 1'b0, "wrap_bad_r");

        fill(64'd0, 0, 0, 0, 8'hFF);
        wr(4'd1, 32'h200, 8'd0, 3'd3, 2'd1, 0, 0, 2'b00, "pre200");
        wd[0] = {8{8'h11}}; wd[1] = {8{8'h22}}; wd[2] = {8{8'h33}};
        ws[0] = 8'h08; ws[1] = 8'h10; ws[2] = 8'h20;
        wr(4'd3, 32'h203, 8'd2, 3'd0, 2'd1, 2, 0, 2'b00, "narrow_w");
        expect4(64'h0000_3322_1100_0000, 0, 0, 0, 2'b00);
        rd(4'd3, 32'h200, 8'd0, 3'd3, 2'd1, 1'b0, "narrow_r");

        fill(64'hB0, 64'hB1, 64'hB2, 64'hB3, 8'hFF);
        wr(4'd4, 32'h300, 8'd3, 3'd3, 2'd0, 3, 0, 2'b00, "fixed_w");
        expect4(64'hB3, 0, 0, 0, 2'b00);
        rd(4'd4, 32'h300, 8'd0, 3'd3, 2'd1, 1'b0, "fixed_r");

        fill(64'hC0, 64'hC1, 0, 0, 8'hFF);
        wr(4'd6, 32'hFF8, 8'd1, 3'd3, 2'd1, 1, 0, 2'b10, "oob_w");
        ed[0] = 64'hC0; er[0] = 2'b00; ed[1] = 64'd0; er[1] = 2'b10;
        rd(4'd6, 32'hFF8, 8'd1, 3'd3, 2'd1, 1'b0, "oob_r");
        expect4(64'h5555_5555_5555_5555, 0, 0, 0, 2'b00);
        rd(4'd7, 32'h000, 8'd0, 3'd3, 2'd1, 1'b0, "oob_nowrap");

        fill(64'h77, 0, 0, 0, 8'hFF);
        wr(4'd9, 32'h400, 8'd0, 3'd3, 2'd1, 0, 5, 2'b00, "bhold_w");
        expect4(64'hA1, 64'hA2, 64'hA3, 64'hA0, 2'b00);
        rd(4'd10, 32'h100, 8'd3, 3'd3, 2'd1, 1'b1, "bp_r");

        fill(64'hD0, 64'hD1, 64'hD2, 0, 8'hFF);
        wr(4'd11, 32'h500, 8'd2, 3'd3, 2'd1, 0, 0, 2'b10, "wlast_early_w");
        expect4(64'hD0, 64'hD1, 64'hD2, 0, 2'b00);
        rd(4'd11, 32'h500, 8'd2, 3'd3, 2'd1, 1'b0, "wlast_early_r");
        fill(64'hF0, 0, 0, 0, 8'hFF);
        wr(4'd12, 32'h520, 8'd0, 3'd3, 2'd1, -1, 0, 2'b10, "wlast_missing_w");

        ARID = 4'd7; ARADDR = 32'h100; ARLEN = 8'd3; ARSIZE = 3'd3; ARBURST = 2'd1; ARVALID = 1'b1;
        hs(2);
        ARVALID = 1'b0;
        RREADY = 1'b1;
        @(negedge ACLK);
        chk("rstmid_beat1", {RVALID, RDATA}, {1'b1, 64'hA1});
        @(posedge ACLK); #1;
        RREADY = 1'b0;
        @(negedge ACLK);
        chk("rstmid_beat2", {RVALID, RDATA}, {1'b1, 64'hA2});
        ARESETn = 1'b0;
        #2;
        chk("rstmid_rvalid", RVALID, 0);
        chk("rstmid_arready", ARREADY, 1);
        chk("rstmid_rlast", RLAST, 0);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        expect4(64'hA1, 0, 0, 0, 2'b00);
        rd(4'd13, 32'h100, 8'd0, 3'd3, 2'd1, 1'b0, "after_rst_r");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
